// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, lane index width.
package lsu_pkg;
  localparam int LANE_W = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    DONE
  } state_e;
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension, and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]      rdata_i,
  input  logic [N-1:0]      wdata_i,
  input  logic [LANE_W-1:0] lane_i,
  input  size_e             size_i,
  input  logic              unsigned_i,
  output logic [N-1:0]      load_o,
  output logic [N-1:0]      merge_o
);

  function automatic logic [N-1:0] extract(input logic [N-1:0] rd, input logic [LANE_W-1:0] lane,
                                           input size_e sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lane, 3'b000} +: 8];
    h = rd[{lane[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: extract = uns ? {{(N-8){1'b0}}, b} : {{(N-8){b[7]}}, b};
      SZ_HALF: extract = uns ? {{(N-16){1'b0}}, h} : {{(N-16){h[15]}}, h};
      default: extract = rd;
    endcase
  endfunction

  function automatic logic [N-1:0] merge(input logic [N-1:0] old, input logic [N-1:0] wd,
                                         input logic [LANE_W-1:0] lane, input size_e sz);
    merge = old;
    case (sz)
      SZ_BYTE: merge[{lane, 3'b000} +: 8] = wd[7:0];
      SZ_HALF: merge[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: merge = wd;
    endcase
  endfunction

  assign load_o  = extract(rdata_i, lane_i, size_i, unsigned_i);
  assign merge_o = merge(rdata_i, wdata_i, lane_i, size_i);

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-addressed memory, with RMW for sub-word stores.
// LSU_MISALIGN_CHECK_EN: misaligned half/word accesses error instead of being force-aligned.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_readdata
);

  size_e               req_sz;
  logic [LANE_W-1:0]   req_lane;
  logic                misalign;
  logic                req_err;

  assign req_sz = size_e'(req_size);

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((req_sz == SZ_HALF) && req_addr[0]) ||
                    ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign req_lane = req_addr[1:0];
`else
  assign misalign = 1'b0;
  assign req_lane = (req_sz == SZ_HALF) ? {req_addr[1], 1'b0} :
                    (req_sz == SZ_WORD) ? 2'b00 : req_addr[1:0];
`endif

  assign req_err = (req_sz == SZ_ILL) || (|req_addr[N-1:M+2]) || misalign;

  state_e            state_q;
  logic              wr_q, uns_q;
  size_e             size_q;
  logic [LANE_W-1:0] lane_q;
  logic [N-1:0]      wdata_q;
  logic              req_ready_q, resp_valid_q, resp_err_q, mem_we_q;
  logic [N-1:0]      resp_rdata_q, mem_addr_q, mem_wdata_q;
  logic [N-1:0]      load_data, merge_data;

  lsu_align #(.N(N)) u_align (
    .rdata_i    (mem_readdata),
    .wdata_i    (wdata_q),
    .lane_i     (lane_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= SZ_BYTE;
      lane_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q         <= req_write;
            uns_q        <= req_unsigned;
            size_q       <= req_sz;
            lane_q       <= req_lane;
            wdata_q      <= req_wdata;
            resp_rdata_q <= '0;
            resp_err_q   <= req_err;
            req_ready_q  <= 1'b0;
            if (req_err) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
            end else begin
              state_q    <= ACCESS;
              mem_addr_q <= {req_addr[N-1:2], 2'b00};
              // Word stores write during ACCESS, so the strobe is set up here.
              if (req_write && (req_sz == SZ_WORD)) begin
                mem_we_q    <= 1'b1;
                mem_wdata_q <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (!wr_q) begin
            resp_rdata_q <= load_data;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else if (size_q == SZ_WORD) begin
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            // mem_wdata doubles as the merge register: the read word with the lane replaced.
            mem_we_q    <= 1'b1;
            mem_wdata_q <= merge_data;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a 32-word memory model and a response scoreboard.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_readdata;
  logic [31:0] tb_mem [0:31];

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          we;
  } vec_t;

  vec_t sb[$];

  always #5 clk = ~clk;

  load_store_unit #(.N(32), .M(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_readdata (mem_readdata)
  );

  assign mem_readdata = tb_mem[mem_addr[6:2]];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr[6:2]] <= mem_wdata;

  // Drives one request, pushes its expectation, and observes the response (bounded wait).
  task automatic issue(input vec_t v, output logic [31:0] rd, output logic er,
                       output int lat, output int we, output int wecyc);
    sb.push_back(v);
    @(negedge clk);
    req_write = v.w; req_size = v.sz; req_unsigned = v.u; req_addr = v.a; req_wdata = v.wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; we = 0; wecyc = 0; rd = 'x; er = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_we) begin we++; wecyc = c; end
      if (resp_valid) begin lat = c; rd = resp_rdata; er = resp_err; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready act=%b exp=1", req_ready); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid act=%b exp=0", resp_valid); else passed++;
    total++; if (resp_rdata !== 32'h0) $display("FAIL reset_resp_rdata act=%h exp=0", resp_rdata); else passed++;
    total++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err act=%b exp=0", resp_err); else passed++;
    total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we act=%b exp=0", mem_we); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr act=%h exp=0", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata act=%h exp=0", mem_wdata); else passed++;
    reset_n = 1'b1;
  endtask

  // Runs a table of transactions; checks response, latency, write-strobe count and memory word.
  task automatic test_table(input string nm, input vec_t tab[], input int midx[], input logic [31:0] mval[]);
    logic [31:0] rd; logic er; int lat, we, wc; vec_t e;
    foreach (tab[i]) begin
      issue(tab[i], rd, er, lat, we, wc);
      e = sb.pop_front();
      total++; if (rd !== e.rd) $display("FAIL %s[%0d] rdata act=%h exp=%h", nm, i, rd, e.rd); else passed++;
      total++; if (er !== e.er) $display("FAIL %s[%0d] err act=%b exp=%b", nm, i, er, e.er); else passed++;
      total++; if (lat !== e.lat) $display("FAIL %s[%0d] latency act=%0d exp=%0d", nm, i, lat, e.lat); else passed++;
      total++; if (we !== e.we) $display("FAIL %s[%0d] mem_we_cycles act=%0d exp=%0d", nm, i, we, e.we); else passed++;
      if (e.we != 0 && e.w && e.sz != 2'b10) begin
        total++; if (wc !== 2) $display("FAIL %s[%0d] we_in_write act=%0d exp=2", nm, i, wc); else passed++;
      end
      if (midx[i] >= 0) begin
        total++;
        if (tb_mem[midx[i]] !== mval[i]) $display("FAIL %s[%0d] mem[%0d] act=%h exp=%h", nm, i, midx[i], tb_mem[midx[i]], mval[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_word();
    vec_t t[] = '{
      '{1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1},
      '{1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0}};
    int mi[] = '{2, 2};
    logic [31:0] mv[] = '{32'hDEADBEEF, 32'hDEADBEEF};
    test_table("word", t, mi, mv);
  endtask

  task automatic test_subword();
    vec_t t[] = '{
      '{1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344, 32'h0, 1'b0, 2, 1},
      '{1'b1, 2'b00, 1'b0, 32'h9, 32'h0000007F, 32'h0, 1'b0, 3, 1},
      '{1'b1, 2'b10, 1'b0, 32'h4, 32'h12345678, 32'h0, 1'b0, 2, 1},
      '{1'b1, 2'b01, 1'b0, 32'h6, 32'h0000BEEF, 32'h0, 1'b0, 3, 1},
      '{1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'h0000BEEF, 1'b0, 2, 0}};
    int mi[] = '{2, 2, 1, 1, -1};
    logic [31:0] mv[] = '{32'h11223344, 32'h11227F44, 32'h12345678, 32'hBEEF5678, 32'h0};
    test_table("subword", t, mi, mv);
  endtask

  task automatic test_extend();
    vec_t t[] = '{
      '{1'b1, 2'b10, 1'b0, 32'h8, 32'h80000000, 32'h0, 1'b0, 2, 1},
      '{1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0},
      '{1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 32'h00000080, 1'b0, 2, 0},
      '{1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFE1234, 32'h0, 1'b0, 2, 1},
      '{1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 32'hFFFFCAFE, 1'b0, 2, 0},
`ifdef LSU_MISALIGN_CHECK_EN
      '{1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1, 0}};
`else
      '{1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'hCAFE1234, 1'b0, 2, 0}};
`endif
    int mi[] = '{2, -1, -1, 0, -1, -1};
    logic [31:0] mv[] = '{32'h80000000, 32'h0, 32'h0, 32'hCAFE1234, 32'h0, 32'h0};
    test_table("extend", t, mi, mv);
  endtask

  task automatic test_errors();
    vec_t t[] = '{
      '{1'b1, 2'b10, 1'b0, 32'h80, 32'h55555555, 32'h0, 1'b1, 1, 0},
      '{1'b1, 2'b10, 1'b0, 32'h7C, 32'h0BADF00D, 32'h0, 1'b0, 2, 1},
      '{1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 32'h0BADF00D, 1'b0, 2, 0},
      '{1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0},
      '{1'b1, 2'b11, 1'b0, 32'h0, 32'h99999999, 32'h0, 1'b1, 1, 0}};
    int mi[] = '{0, 31, -1, -1, 0};
    logic [31:0] mv[] = '{32'hCAFE1234, 32'h0BADF00D, 32'h0, 32'h0, 32'hCAFE1234};
    test_table("errors", t, mi, mv);
  endtask

  task automatic test_reset_mid_write();
    vec_t p = '{1'b1, 2'b10, 1'b0, 32'hC, 32'hAABBCCDD, 32'h0, 1'b0, 2, 1};
    logic [31:0] rd; logic er; int lat, we, wc; vec_t e;
    issue(p, rd, er, lat, we, wc);
    e = sb.pop_front();
    total++; if (lat !== e.lat) $display("FAIL rmw_preload latency act=%0d exp=%0d", lat, e.lat); else passed++;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_addr = 32'hC; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    total++; if (mem_we !== 1'b1) $display("FAIL rmw_we_in_write act=%b exp=1", mem_we); else passed++;
    reset_n = 1'b0;
    #1;
    total++; if (mem_we !== 1'b0) $display("FAIL rmw_reset_we act=%b exp=0", mem_we); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL rmw_reset_ready act=%b exp=1", req_ready); else passed++;
    total++; if (resp_valid !== 1'b0) $display("FAIL rmw_reset_valid act=%b exp=0", resp_valid); else passed++;
    @(posedge clk);
    #1;
    total++; if (tb_mem[3] !== 32'hAABBCCDD) $display("FAIL rmw_reset_mem act=%h exp=aabbccdd", tb_mem[3]); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_stall();
    vec_t p = '{1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 32'h0BADF00D, 1'b0, 2, 0};
    logic [31:0] rd; logic er; int lat, we, wc; vec_t e;
    int bad_v = 0, bad_d = 0, bad_r = 0;
    resp_ready = 1'b0;
    issue(p, rd, er, lat, we, wc);
    e = sb.pop_front();
    total++; if (rd !== e.rd) $display("FAIL stall rdata act=%h exp=%h", rd, e.rd); else passed++;
    total++; if (lat !== e.lat) $display("FAIL stall latency act=%0d exp=%0d", lat, e.lat); else passed++;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 1'b1) bad_v++;
      if (resp_rdata !== e.rd) bad_d++;
      if (req_ready !== 1'b0) bad_r++;
    end
    total++; if (bad_v != 0) $display("FAIL stall_valid_held drops=%0d exp=0", bad_v); else passed++;
    total++; if (bad_d != 0) $display("FAIL stall_rdata_held changes=%0d exp=0", bad_d); else passed++;
    total++; if (bad_r != 0) $display("FAIL stall_req_ready_low highs=%0d exp=0", bad_r); else passed++;
    resp_ready = 1'b1;
    @(negedge clk);
    total++; if (resp_valid !== 1'b0) $display("FAIL stall_release valid act=%b exp=0", resp_valid); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL stall_release ready act=%b exp=1", req_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_extend();
    test_errors();
    test_reset_mid_write();
    test_stall();
    total++; if (sb.size() != 0) $display("FAIL scoreboard_leftover act=%0d exp=0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
